retire_queue: RTL and testbench

Holds the stale physical register tags displaced at rename until their instructions commit, then hands up to four per cycle to the free list as its retire inputs (`ret_p0..3`, `ret_count`). It is the release end of the physical register pool: the free list pops tags at rename, and this block pushes them back. It is a 4-in/4-out circular FIFO with commit-driven release and a flush that discards uncommitted entries.

---
 rtl/retire_queue_pkg.sv | 20 ++
 rtl/retire_queue_if.sv | 51 +++++
 rtl/retire_queue_chk.sv | 30 +++
 rtl/retire_queue_read4.sv | 30 +++
 rtl/retire_queue.sv | 155 +++++++++++++++
 tb/tb_retire_queue.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/retire_queue_pkg.sv
// -----------------------------------------------------------------------------
// retire_queue_pkg
// Shared rename constants and types: physical register count, tag width,
// rename width and the physical tag type used by the free list, rename map
// and retire queue. Also holds a small helper used by request clamping.
// -----------------------------------------------------------------------------
package retire_queue_pkg;

    localparam int PREGS    = 48;
    localparam int PBITS    = $clog2(PREGS);
    localparam int RN_WIDTH = 4;

    typedef logic [PBITS-1:0] ptag_t;

    // Smaller of two 3-bit counts (used to clamp a release request).
    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/retire_queue_if.sv
// -----------------------------------------------------------------------------
// retire_queue_if
// Bundles the retire queue's enqueue, commit/flush and release signals.
//   master : upstream side (rename/commit logic, or a bench)
//   slave  : the retire queue itself
// Signals:
//   i_enq_count, i_enq_p0..3   stale tags written this cycle
//   o_enq_ready                at least four free entries
//   i_commit_count, i_flush    release request / discard of uncommitted entries
//   o_ret_p0..3, o_ret_count   tags handed to the free list
//   o_count                    occupancy
//   o_err                      sticky protocol-violation flag
// -----------------------------------------------------------------------------
interface retire_queue_if #(
    parameter int DEPTH = 32
);
    import retire_queue_pkg::*;

    localparam int CBITS = $clog2(DEPTH + 1);

    logic [2:0]       i_enq_count;
    ptag_t            i_enq_p0;
    ptag_t            i_enq_p1;
    ptag_t            i_enq_p2;
    ptag_t            i_enq_p3;
    logic             o_enq_ready;
    logic [2:0]       i_commit_count;
    logic             i_flush;
    ptag_t            o_ret_p0;
    ptag_t            o_ret_p1;
    ptag_t            o_ret_p2;
    ptag_t            o_ret_p3;
    logic [2:0]       o_ret_count;
    logic [CBITS-1:0] o_count;
    logic             o_err;

    modport master (
        output i_enq_count, i_enq_p0, i_enq_p1, i_enq_p2, i_enq_p3,
        output i_commit_count, i_flush,
        input  o_enq_ready, o_ret_p0, o_ret_p1, o_ret_p2, o_ret_p3,
        input  o_ret_count, o_count, o_err
    );

    modport slave (
        input  i_enq_count, i_enq_p0, i_enq_p1, i_enq_p2, i_enq_p3,
        input  i_commit_count, i_flush,
        output o_enq_ready, o_ret_p0, o_ret_p1, o_ret_p2, o_ret_p3,
        output o_ret_count, o_count, o_err
    );

endinterface

// File: rtl/retire_queue_chk.sv
// -----------------------------------------------------------------------------
// retire_queue_chk
// Structural invariants of the retire queue: occupancy never exceeds DEPTH,
// head + count equals tail modulo DEPTH, and at most four tags are released.
// Ports: clk_i, rst_n_i, head_i, tail_i, count_i, ret_count_i.
// -----------------------------------------------------------------------------
module retire_queue_chk #(
    parameter int DEPTH = 32
) (
    input logic                         clk_i,
    input logic                         rst_n_i,
    input logic [$clog2(DEPTH)-1:0]     head_i,
    input logic [$clog2(DEPTH)-1:0]     tail_i,
    input logic [$clog2(DEPTH+1)-1:0]   count_i,
    input logic [2:0]                   ret_count_i
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CBITS = $clog2(DEPTH + 1);

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_i <= CBITS'(DEPTH));

    a_ptr_consistent: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (head_i + AW'(count_i)) == tail_i);

    a_ret_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ret_count_i <= 3'd4);

endmodule

// File: rtl/retire_queue_read4.sv
// -----------------------------------------------------------------------------
// retq_read4
// Combinational four-port read of consecutive entries starting at the head.
// The index arithmetic is done at pointer width, so reads straddling the last
// entry wrap to entry 0 naturally (DEPTH is a power of two).
// Ports:
//   mem_i   queue storage
//   head_i  oldest entry index
//   rd_o    entries head+0 .. head+3
// -----------------------------------------------------------------------------
module retq_read4
    import retire_queue_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  ptag_t                      mem_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    output ptag_t                      rd_o  [RN_WIDTH]
);

    localparam int AW = $clog2(DEPTH);

    // Read mux for each release port.
    always_comb begin
        for (int k = 0; k < RN_WIDTH; k++) begin
            rd_o[k] = mem_i[head_i + AW'(k)];
        end
    end

endmodule

// File: rtl/retire_queue.sv
// -----------------------------------------------------------------------------
// retire_queue
// Holds stale physical tags displaced at rename until their instructions
// commit, then releases up to four per cycle to the free list. 4-in/4-out
// circular FIFO with commit-driven release and a flush that discards every
// entry not committed in the flush cycle.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   q        retire_queue_if.slave (enqueue, commit/flush, release, status)
// Build option:
//   RETQ_CHECK_EN  clamp illegal requests and raise sticky o_err; with FORMAL
//                  also defined, structural assertions are bound in.
// -----------------------------------------------------------------------------
module retire_queue
    import retire_queue_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    retire_queue_if.slave q
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CBITS = $clog2(DEPTH + 1);

    ptag_t            mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CBITS-1:0] count_q, count_d;
    logic             enq_ready_q, enq_ready_d;
    ptag_t            ret_p_q [RN_WIDTH];
    logic [2:0]       ret_count_q;
    ptag_t            rd_s    [RN_WIDTH];
    ptag_t            enq_p_s [RN_WIDTH];
    logic [2:0]       commit_eff_s;
    logic [2:0]       enq_eff_s;

    assign enq_p_s[0] = q.i_enq_p0;
    assign enq_p_s[1] = q.i_enq_p1;
    assign enq_p_s[2] = q.i_enq_p2;
    assign enq_p_s[3] = q.i_enq_p3;

`ifdef RETQ_CHECK_EN
    logic [2:0]       cap_s;
    logic [CBITS:0]   occ_s;
    logic             enq_bad_s;
    logic             viol_s;
    logic             err_q;

    // Clamp the request: release at most min(count, 4); drop a whole enqueue
    // that is oversized or would overflow after this cycle's release.
    always_comb begin
        cap_s        = (count_q >= CBITS'(RN_WIDTH)) ? 3'(RN_WIDTH) : count_q[2:0];
        commit_eff_s = min3(q.i_commit_count, cap_s);
        occ_s        = {1'b0, count_q} - (CBITS+1)'(commit_eff_s)
                     + (CBITS+1)'(q.i_enq_count);
        enq_bad_s    = (q.i_enq_count > 3'(RN_WIDTH)) || (occ_s > (CBITS+1)'(DEPTH));
        if (enq_bad_s) begin
            enq_eff_s = 3'd0;
        end else begin
            enq_eff_s = q.i_enq_count;
        end
        viol_s = (q.i_commit_count > cap_s) || enq_bad_s;
    end

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | viol_s;
        end
    end

    assign q.o_err = err_q;

`ifdef FORMAL
    retire_queue_chk #(.DEPTH(DEPTH)) u_chk (
        .clk_i       (i_clk),
        .rst_n_i     (i_rst_n),
        .head_i      (head_q),
        .tail_i      (tail_q),
        .count_i     (count_q),
        .ret_count_i (ret_count_q)
    );
`endif
`else
    assign commit_eff_s = q.i_commit_count;
    assign enq_eff_s    = q.i_enq_count;
    assign q.o_err      = 1'b0;
`endif

    // Next pointers and occupancy. A flush keeps this cycle's release and
    // collapses the queue onto the new head, dropping any same-cycle enqueue.
    always_comb begin
        head_d = head_q + AW'(commit_eff_s);
        if (q.i_flush) begin
            tail_d  = head_q + AW'(commit_eff_s);
            count_d = {CBITS{1'b0}};
        end else begin
            tail_d  = tail_q + AW'(enq_eff_s);
            count_d = count_q + CBITS'(enq_eff_s) - CBITS'(commit_eff_s);
        end
        enq_ready_d = ({1'b0, count_d} + (CBITS+1)'(RN_WIDTH)) <= (CBITS+1)'(DEPTH);
    end

    // Pointer, occupancy and release registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_q      <= {AW{1'b0}};
            tail_q      <= {AW{1'b0}};
            count_q     <= {CBITS{1'b0}};
            enq_ready_q <= 1'b1;
            ret_count_q <= 3'd0;
            for (int k = 0; k < RN_WIDTH; k++) begin
                ret_p_q[k] <= {PBITS{1'b0}};
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            enq_ready_q <= enq_ready_d;
            ret_count_q <= commit_eff_s;
            for (int k = 0; k < RN_WIDTH; k++) begin
                ret_p_q[k] <= rd_s[k];
            end
        end
    end

    // Storage write: slot k lands at tail+k, wrapping at pointer width.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < RN_WIDTH; k++) begin
            if (!q.i_flush && (3'(k) < enq_eff_s)) begin
                mem_q[tail_q + AW'(k)] <= enq_p_s[k];
            end
        end
    end

    retq_read4 #(.DEPTH(DEPTH)) u_read4 (
        .mem_i  (mem_q),
        .head_i (head_q),
        .rd_o   (rd_s)
    );

    assign q.o_ret_p0    = ret_p_q[0];
    assign q.o_ret_p1    = ret_p_q[1];
    assign q.o_ret_p2    = ret_p_q[2];
    assign q.o_ret_p3    = ret_p_q[3];
    assign q.o_ret_count = ret_count_q;
    assign q.o_count     = count_q;
    assign q.o_enq_ready = enq_ready_q;

endmodule

// File: tb/tb_retire_queue.sv
module tb_retire_queue;
    import retire_queue_pkg::*;

    localparam int DEPTH = 32;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    retire_queue_if #(.DEPTH(DEPTH)) bus ();

    retire_queue #(.DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .q       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain FIFO of tags plus a sticky error bit.
    int mq[$];
    int m_err = 0;

    typedef struct {
        int n; int t0; int t1; int t2; int t3; int m; bit f;
        int e_rc; int e_p0; int e_p1; int e_cnt; bit e_rdy;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ret_p(input int k);
        case (k)
            0: return int'(bus.o_ret_p0);
            1: return int'(bus.o_ret_p1);
            2: return int'(bus.o_ret_p2);
            default: return int'(bus.o_ret_p3);
        endcase
    endfunction

    // One clock with the given request; the model is advanced and compared.
    task automatic cycle(input int n, input int t0, input int t1, input int t2,
                         input int t3, input int m, input bit f);
        int tags[4];
        int exp_ret[4];
        int me;
        int ok;
        tags[0] = t0; tags[1] = t1; tags[2] = t2; tags[3] = t3;
        bus.i_enq_count    = 3'(n);
        bus.i_enq_p0       = ptag_t'(t0);
        bus.i_enq_p1       = ptag_t'(t1);
        bus.i_enq_p2       = ptag_t'(t2);
        bus.i_enq_p3       = ptag_t'(t3);
        bus.i_commit_count = 3'(m);
        bus.i_flush        = f;
        @(posedge i_clk);
        #1;
        me = m;
`ifdef RETQ_CHECK_EN
        if (me > 4) me = 4;
        if (me > mq.size()) me = mq.size();
        if (m > me) m_err = 1;
`endif
        for (int k = 0; k < me; k++) exp_ret[k] = mq.pop_front();
        if (f) begin
            mq.delete();
        end else begin
            ok = 1;
`ifdef RETQ_CHECK_EN
            if (n > 4 || mq.size() + n > DEPTH) begin
                ok = 0;
                m_err = 1;
            end
`endif
            if (ok != 0) for (int k = 0; k < n && k < 4; k++) mq.push_back(tags[k]);
        end
        chk("ret_count", int'(bus.o_ret_count), me);
        for (int k = 0; k < me; k++) chk($sformatf("ret_p%0d", k), ret_p(k), exp_ret[k]);
        chk("count", int'(bus.o_count), mq.size());
        chk("enq_ready", int'(bus.o_enq_ready), (DEPTH - mq.size()) >= 4 ? 1 : 0);
        chk("err", int'(bus.o_err), m_err);
    endtask

    task automatic idle_inputs();
        bus.i_enq_count = 3'd0; bus.i_commit_count = 3'd0; bus.i_flush = 1'b0;
        bus.i_enq_p0 = '0; bus.i_enq_p1 = '0; bus.i_enq_p2 = '0; bus.i_enq_p3 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        mq.delete();
        m_err = 0;
        chk("rst_ret_count", int'(bus.o_ret_count), 0);
        chk("rst_count", int'(bus.o_count), 0);
        chk("rst_enq_ready", int'(bus.o_enq_ready), 1);
        chk("rst_err", int'(bus.o_err), 0);
        for (int k = 0; k < 4; k++) chk($sformatf("rst_ret_p%0d", k), ret_p(k), 0);
    endtask

    function automatic int rt();
        return int'($urandom_range(0, PREGS - 1));
    endfunction

    initial begin
        int sz; int m; int n; int room; bit f;

        // Basic sequence with hand-computed expectations.
        tbl[0] = '{3, 5, 9, 12, 0, 0, 1'b0, 0, 0, 0, 3, 1'b1};
        tbl[1] = '{1, 20, 0, 0, 0, 0, 1'b0, 0, 0, 0, 4, 1'b1};
        tbl[2] = '{0, 0, 0, 0, 0, 2, 1'b0, 2, 5, 9, 2, 1'b1};
        tbl[3] = '{0, 0, 0, 0, 0, 2, 1'b0, 2, 12, 20, 0, 1'b1};
        tbl[4] = '{2, 33, 47, 0, 0, 0, 1'b0, 0, 0, 0, 2, 1'b1};
        tbl[5] = '{3, 1, 2, 3, 0, 1, 1'b1, 1, 33, 0, 0, 1'b1};
        tbl[6] = '{2, 7, 8, 0, 0, 0, 1'b0, 0, 0, 0, 2, 1'b1};
        tbl[7] = '{0, 0, 0, 0, 0, 2, 1'b0, 2, 7, 8, 0, 1'b1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].n, tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].t3, tbl[i].m, tbl[i].f);
            chk($sformatf("tbl%0d_ret_count", i), int'(bus.o_ret_count), tbl[i].e_rc);
            if (tbl[i].e_rc >= 1) chk($sformatf("tbl%0d_p0", i), int'(bus.o_ret_p0), tbl[i].e_p0);
            if (tbl[i].e_rc >= 2) chk($sformatf("tbl%0d_p1", i), int'(bus.o_ret_p1), tbl[i].e_p1);
            chk($sformatf("tbl%0d_count", i), int'(bus.o_count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ready", i), int'(bus.o_enq_ready), int'(tbl[i].e_rdy));
        end

        // Fill to full from a fresh head, then enqueue while committing at full.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(4, rt(), rt(), rt(), rt(), 0, 1'b0);
        chk("full_count", int'(bus.o_count), 32);
        chk("full_ready", int'(bus.o_enq_ready), 0);
        cycle(4, rt(), rt(), rt(), rt(), 4, 1'b0);
        chk("full_swap_count", int'(bus.o_count), 32);
        // Drain until head sits at entry 30 with six entries left.
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 4, 1'b0);
        cycle(0, 0, 0, 0, 0, 2, 1'b0);
        chk("wrap_pre_count", int'(bus.o_count), 6);
        // Release from entries 30,31,0,1.
        cycle(0, 0, 0, 0, 0, 4, 1'b0);
        chk("wrap_ret_count", int'(bus.o_ret_count), 4);
        cycle(0, 0, 0, 0, 0, 2, 1'b0);

        // Flush at count 5 with commit 1 and enqueue 3.
        cycle(4, rt(), rt(), rt(), rt(), 0, 1'b0);
        cycle(1, rt(), 0, 0, 0, 0, 1'b0);
        cycle(3, 41, 42, 43, 0, 1, 1'b1);
        chk("flush_count", int'(bus.o_count), 0);
        chk("flush_ret_count", int'(bus.o_ret_count), 1);
        cycle(2, 10, 11, 0, 0, 0, 1'b0);
        cycle(0, 0, 0, 0, 0, 2, 1'b0);
        chk("post_flush_p0", int'(bus.o_ret_p0), 10);
        chk("post_flush_p1", int'(bus.o_ret_p1), 11);

`ifdef RETQ_CHECK_EN
        // Over-commit is clamped and latches the error flag.
        cycle(1, 30, 0, 0, 0, 0, 1'b0);
        cycle(0, 0, 0, 0, 0, 3, 1'b0);
        chk("clamp_ret_count", int'(bus.o_ret_count), 1);
        chk("clamp_err", int'(bus.o_err), 1);
        cycle(0, 0, 0, 0, 0, 0, 1'b0);
        chk("err_held", int'(bus.o_err), 1);
        do_reset();
`endif

        // Randomized legal traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sz   = mq.size();
            m    = int'($urandom_range(0, (sz < 4) ? sz : 4));
            room = DEPTH - sz + m;
            n    = int'($urandom_range(0, (room < 4) ? room : 4));
            f    = ($urandom_range(0, 15) == 0);
            cycle(n, rt(), rt(), rt(), rt(), m, f);
        end

        // Reset asserted in a commit cycle.
        cycle(4, rt(), rt(), rt(), rt(), 0, 1'b0);
        bus.i_commit_count = 3'd2;
        bus.i_enq_count    = 3'd0;
        bus.i_flush        = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        chk("midrst_ret_count", int'(bus.o_ret_count), 0);
        chk("midrst_count", int'(bus.o_count), 0);
        chk("midrst_ready", int'(bus.o_enq_ready), 1);
        chk("midrst_err", int'(bus.o_err), 0);
        i_rst_n = 1'b1;
        mq.delete();
        m_err = 0;
        idle_inputs();
        cycle(2, 3, 4, 0, 0, 0, 1'b0);
        cycle(0, 0, 0, 0, 0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
